// File: rtl/floor_pkg.sv
// Shared types and constants for the platform scheduler slice.
package floor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2,
    OVER = 2'd3
  } state_t;

  localparam int unsigned SCREEN_H = 480;
  localparam int unsigned FLOOR_W  = 40;

  localparam logic [9:0] INIT_X [4] = '{10'd290, 10'd120, 10'd450, 10'd290};
  localparam logic [9:0] INIT_Y [4] = '{10'd400, 10'd280, 10'd160, 10'd40};

  // x^10 + x^7 + 1 -> feedback from bits 9 and 6
  localparam logic [9:0] LFSR_SEED = 10'h2A5;
  localparam logic [9:0] LFSR_TAPS = 10'h240;

endpackage

// File: rtl/floor_scheduler_if.sv
// Game-FSM controls in, platform slot state out.
interface floor_scheduler_if;
  logic        tick;
  logic        start;
  logic [9:0]  slime_y;
  logic [9:0]  floor_pos_x0, floor_pos_x1, floor_pos_x2, floor_pos_x3;
  logic [9:0]  floor_pos_y0, floor_pos_y1, floor_pos_y2, floor_pos_y3;
  logic [3:0]  enable;
  logic        scroll;
  logic [15:0] score;
  logic        game_over;

  modport master (
    output tick, start, slime_y,
    input  floor_pos_x0, floor_pos_x1, floor_pos_x2, floor_pos_x3,
    input  floor_pos_y0, floor_pos_y1, floor_pos_y2, floor_pos_y3,
    input  enable, scroll, score, game_over
  );

  modport slave (
    input  tick, start, slime_y,
    output floor_pos_x0, floor_pos_x1, floor_pos_x2, floor_pos_x3,
    output floor_pos_y0, floor_pos_y1, floor_pos_y2, floor_pos_y3,
    output enable, scroll, score, game_over
  );
endinterface

// File: rtl/floor_lfsr.sv
// Free-running 10-bit Fibonacci LFSR used for platform x placement.
module floor_lfsr
  import floor_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] value
);

  always_ff @(posedge clk) begin
    if (rst) value <= LFSR_SEED;
    else     value <= {value[8:0], ^(value & LFSR_TAPS)};
  end

endmodule

// File: rtl/floor_scheduler.sv
// Scrolls, retires and respawns the four platform slots; tracks score and game-over.
module floor_scheduler
  import floor_pkg::*;
#(
  parameter int unsigned SCROLL_LINE = 200,
  parameter int unsigned SPAWN_GAP   = 120,
  parameter int unsigned X_MAX       = 580
)(
  input  logic               clk,
  input  logic               rst,
  floor_scheduler_if.slave   bus
);

  localparam int unsigned     CW     = $clog2(SPAWN_GAP + 1);
  localparam logic [CW-1:0]   GAP    = CW'(SPAWN_GAP);
  localparam logic [9:0]      Y_LAST = 10'(SCREEN_H - 1);

  state_t        state;
  logic [9:0]    pos_x [4];
  logic [9:0]    pos_y [4];
  logic [3:0]    en;
  logic [CW-1:0] gap_cnt;
  logic [15:0]   score;
  logic          scroll;
  logic          game_over;
  logic [9:0]    lfsr;

  logic          do_scroll;
  logic          do_spawn;
  logic          have_free;
  logic [1:0]    spawn_idx;
  logic [CW-1:0] cnt_next;
  logic [9:0]    spawn_x;
  logic [9:0]    y_next [4];
  logic [3:0]    en_next;

  floor_lfsr u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .value (lfsr)
  );

  // Priority encoder: scanning high-to-low lets the lowest free index win.
  always_comb begin
    have_free = 1'b0;
    spawn_idx = '0;
    for (int unsigned i = 4; i > 0; i--) begin
      if (!en[i-1]) begin
        have_free = 1'b1;
        spawn_idx = 2'(i - 1);
      end
    end
  end

  always_comb begin
    do_scroll = bus.slime_y < 10'(SCROLL_LINE);
    cnt_next  = (do_scroll && gap_cnt != GAP) ? gap_cnt + 1'b1 : gap_cnt;
    do_spawn  = (cnt_next == GAP) && have_free;
    spawn_x   = (lfsr < 10'(X_MAX)) ? lfsr : lfsr - 10'd512;
    for (int unsigned i = 0; i < 4; i++) begin
      y_next[i]  = (en[i] && do_scroll) ? pos_y[i] + 10'd1 : pos_y[i];
      en_next[i] = en[i] && (y_next[i] < Y_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      en        <= '0;
      gap_cnt   <= '0;
      score     <= '0;
      scroll    <= 1'b0;
      game_over <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
        pos_x[i] <= '0;
        pos_y[i] <= '0;
      end
    end else begin
      scroll <= 1'b0;
      case (state)
        IDLE: if (bus.start) state <= INIT;
        INIT: begin
          for (int unsigned i = 0; i < 4; i++) begin
            pos_x[i] <= INIT_X[i];
            pos_y[i] <= INIT_Y[i];
          end
          en      <= '1;
          score   <= '0;
          gap_cnt <= '0;
          state   <= RUN;
        end
        RUN: if (bus.tick) begin
          if (bus.slime_y == Y_LAST) begin
            state     <= OVER;
            game_over <= 1'b1;
          end else begin
            for (int unsigned i = 0; i < 4; i++) pos_y[i] <= y_next[i];
            en      <= en_next;
            gap_cnt <= cnt_next;
            if (do_scroll) begin
              scroll <= 1'b1;
              if (score != '1) score <= score + 16'd1;
            end
            // Spawn target was free before this tick, so it never collides with a retire.
            if (do_spawn) begin
              pos_x[spawn_idx] <= spawn_x;
              pos_y[spawn_idx] <= '0;
              en[spawn_idx]    <= 1'b1;
              gap_cnt          <= '0;
            end
          end
        end
        OVER: if (bus.start) begin
          state     <= INIT;
          game_over <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.floor_pos_x0 = pos_x[0];
  assign bus.floor_pos_x1 = pos_x[1];
  assign bus.floor_pos_x2 = pos_x[2];
  assign bus.floor_pos_x3 = pos_x[3];
  assign bus.floor_pos_y0 = pos_y[0];
  assign bus.floor_pos_y1 = pos_y[1];
  assign bus.floor_pos_y2 = pos_y[2];
  assign bus.floor_pos_y3 = pos_y[3];
  assign bus.enable       = en;
  assign bus.scroll       = scroll;
  assign bus.score        = score;
  assign bus.game_over    = game_over;

endmodule

// File: tb/tb_floor_scheduler.sv
// Two schedulers (default gap and a short gap) driven in lockstep against a behavioural model.
module tb_floor_scheduler;

  logic       clk = 1'b0;
  logic       rst, start, tick;
  logic [9:0] slime_y;
  bit         chk_on = 1'b0;
  int         n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  floor_scheduler_if bus_a ();
  floor_scheduler_if bus_b ();

  assign bus_a.tick = tick;  assign bus_a.start = start;  assign bus_a.slime_y = slime_y;
  assign bus_b.tick = tick;  assign bus_b.start = start;  assign bus_b.slime_y = slime_y;

  floor_scheduler u_dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  floor_scheduler #(.SPAWN_GAP(40)) u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  logic [9:0]  ox [2][4];
  logic [9:0]  oy [2][4];
  logic [3:0]  oen [2];
  logic        osc [2];
  logic [15:0] oscore [2];
  logic        ogo [2];

  assign ox[0][0] = bus_a.floor_pos_x0;  assign ox[0][1] = bus_a.floor_pos_x1;
  assign ox[0][2] = bus_a.floor_pos_x2;  assign ox[0][3] = bus_a.floor_pos_x3;
  assign oy[0][0] = bus_a.floor_pos_y0;  assign oy[0][1] = bus_a.floor_pos_y1;
  assign oy[0][2] = bus_a.floor_pos_y2;  assign oy[0][3] = bus_a.floor_pos_y3;
  assign ox[1][0] = bus_b.floor_pos_x0;  assign ox[1][1] = bus_b.floor_pos_x1;
  assign ox[1][2] = bus_b.floor_pos_x2;  assign ox[1][3] = bus_b.floor_pos_x3;
  assign oy[1][0] = bus_b.floor_pos_y0;  assign oy[1][1] = bus_b.floor_pos_y1;
  assign oy[1][2] = bus_b.floor_pos_y2;  assign oy[1][3] = bus_b.floor_pos_y3;
  assign oen[0] = bus_a.enable;    assign oen[1] = bus_b.enable;
  assign osc[0] = bus_a.scroll;    assign osc[1] = bus_b.scroll;
  assign oscore[0] = bus_a.score;  assign oscore[1] = bus_b.score;
  assign ogo[0] = bus_a.game_over; assign ogo[1] = bus_b.game_over;

  // ---------------- behavioural model ----------------
  // phase: 0 waiting for start, 1 loading, 2 playing, 3 game over
  int m_phase [2];
  int m_x [2][4];
  int m_y [2][4];
  bit m_en [2][4];
  int m_score [2], m_cnt [2], m_lfsr [2];
  bit m_scroll [2], m_over [2];
  int m_gap [2] = '{120, 40};

  function automatic void model_edge(int k);
    int  lf, fb;
    bit  was_free [4];
    if (rst) begin
      m_phase[k] = 0; m_score[k] = 0; m_cnt[k] = 0; m_lfsr[k] = 'h2A5;
      m_scroll[k] = 0; m_over[k] = 0;
      for (int i = 0; i < 4; i++) begin m_x[k][i] = 0; m_y[k][i] = 0; m_en[k][i] = 0; end
      return;
    end
    lf = m_lfsr[k];
    fb = ((lf >> 9) ^ (lf >> 6)) & 1;
    m_lfsr[k] = ((lf << 1) & 'h3FF) | fb;
    m_scroll[k] = 0;
    case (m_phase[k])
      0: if (start) m_phase[k] = 1;
      1: begin
        m_x[k] = '{290, 120, 450, 290};
        m_y[k] = '{400, 280, 160, 40};
        for (int i = 0; i < 4; i++) m_en[k][i] = 1;
        m_score[k] = 0; m_cnt[k] = 0; m_phase[k] = 2;
      end
      2: if (tick) begin
        if (slime_y == 479) begin
          m_phase[k] = 3; m_over[k] = 1;
        end else begin
          for (int i = 0; i < 4; i++) was_free[i] = !m_en[k][i];
          if (slime_y < 200) begin
            for (int i = 0; i < 4; i++) if (m_en[k][i]) m_y[k][i]++;
            m_scroll[k] = 1;
            if (m_score[k] < 65535) m_score[k]++;
            if (m_cnt[k] < m_gap[k]) m_cnt[k]++;
          end
          for (int i = 0; i < 4; i++) if (m_en[k][i] && m_y[k][i] >= 479) m_en[k][i] = 0;
          if (m_cnt[k] == m_gap[k]) begin
            for (int i = 0; i < 4; i++) begin
              if (was_free[i]) begin
                m_x[k][i] = (lf < 580) ? lf : lf - 512;
                m_y[k][i] = 0; m_en[k][i] = 1; m_cnt[k] = 0;
                break;
              end
            end
          end
        end
      end
      3: if (start) begin m_phase[k] = 1; m_over[k] = 0; end
      default: m_phase[k] = 0;
    endcase
  endfunction

  always @(posedge clk) begin
    model_edge(0);
    model_edge(1);
  end

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < 2; k++) begin
        int exp_en;
        exp_en = 0;
        for (int i = 0; i < 4; i++) begin
          chk($sformatf("dut%0d_x%0d", k, i), int'(ox[k][i]), m_x[k][i]);
          chk($sformatf("dut%0d_y%0d", k, i), int'(oy[k][i]), m_y[k][i]);
          exp_en |= int'(m_en[k][i]) << i;
        end
        chk($sformatf("dut%0d_enable", k), int'(oen[k]), exp_en);
        chk($sformatf("dut%0d_scroll", k), int'(osc[k]), int'(m_scroll[k]));
        chk($sformatf("dut%0d_score", k), int'(oscore[k]), m_score[k]);
        chk($sformatf("dut%0d_game_over", k), int'(ogo[k]), int'(m_over[k]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  int pulses;

  initial begin
    rst = 1'b1; start = 1'b0; tick = 1'b0; slime_y = 10'd300;
    step(); chk_on = 1'b1; step();
    chk("reset_enable", int'(bus_a.enable), 0);
    chk("reset_score", int'(bus_a.score), 0);
    chk("reset_y0", int'(bus_a.floor_pos_y0), 0);
    rst = 1'b0; tick = 1'b1; step(); tick = 1'b0;
    chk("idle_tick_ignored", int'(bus_a.enable), 0);

    start = 1'b1; step(); start = 1'b0; step();
    chk("init_enable", int'(bus_a.enable), 15);
    chk("init_y0", int'(bus_a.floor_pos_y0), 400);
    chk("init_y1", int'(bus_a.floor_pos_y1), 280);
    chk("init_y2", int'(bus_a.floor_pos_y2), 160);
    chk("init_y3", int'(bus_a.floor_pos_y3), 40);
    chk("init_x2", int'(bus_a.floor_pos_x2), 450);

    slime_y = 10'd150; tick = 1'b1; pulses = 0;
    repeat (10) begin step(); pulses += int'(bus_a.scroll); end
    chk("ten_scroll_pulses", pulses, 10);
    chk("ten_score", int'(bus_a.score), 10);
    chk("ten_y0", int'(bus_a.floor_pos_y0), 410);
    chk("ten_y3", int'(bus_a.floor_pos_y3), 50);

    repeat (30) step();                         // 40 scrolls
    chk("gap40_deferred_enable", int'(bus_b.enable), 15);
    start = 1'b1; step(); start = 1'b0;         // start ignored in RUN
    repeat (37) step();                         // 78
    chk("pre_retire_y0", int'(bus_a.floor_pos_y0), 478);
    chk("pre_retire_enable", int'(bus_a.enable), 15);
    step();                                     // 79: slot0 hits 479
    chk("retire_enable_a", int'(bus_a.enable), 4'b1110);
    chk("retire_enable_b", int'(bus_b.enable), 4'b1110);
    chk("retire_y0", int'(bus_a.floor_pos_y0), 479);
    step();                                     // 80: deferred spawn fires in b
    chk("deferred_spawn_enable_b", int'(bus_b.enable), 15);
    chk("deferred_spawn_y0_b", int'(bus_b.floor_pos_y0), 0);
    chk("deferred_spawn_x0_b_range", int'(bus_b.floor_pos_x0 < 10'd580), 1);
    chk("no_early_spawn_a", int'(bus_a.enable), 4'b1110);
    repeat (40) step();                         // 120
    chk("respawn_enable_a", int'(bus_a.enable), 15);
    chk("respawn_y0_a", int'(bus_a.floor_pos_y0), 0);
    chk("respawn_x0_a_range", int'(bus_a.floor_pos_x0 < 10'd580), 1);
    chk("respawn_y1_a", int'(bus_a.floor_pos_y1), 400);

    slime_y = 10'd300; repeat (5) step();
    chk("noscroll_score", int'(bus_a.score), 120);
    slime_y = 10'd479; step();
    chk("over_flag", int'(bus_a.game_over), 1);
    chk("over_no_scroll", int'(bus_a.score), 120);
    slime_y = 10'd150; repeat (3) step();
    chk("over_frozen_y1", int'(bus_a.floor_pos_y1), 400);
    chk("over_frozen_score", int'(bus_a.score), 120);

    tick = 1'b0; start = 1'b1; step(); start = 1'b0;
    chk("restart_clears_over", int'(bus_a.game_over), 0);
    step();
    chk("restart_y0", int'(bus_a.floor_pos_y0), 400);
    chk("restart_score", int'(bus_a.score), 0);

    tick = 1'b1; repeat (5) step();
    rst = 1'b1; step(); rst = 1'b0;
    chk("midrun_reset_enable", int'(bus_a.enable), 0);
    chk("midrun_reset_y2", int'(bus_a.floor_pos_y2), 0);
    repeat (3) step();
    chk("post_reset_ticks_ignored", int'(bus_a.score), 0);

    start = 1'b1; step(); start = 1'b0; step();  // tick held high: dropped
    chk("start_tick_together_score", int'(bus_a.score), 0);
    chk("start_tick_together_y0", int'(bus_a.floor_pos_y0), 400);
    step();
    chk("first_run_tick_score", int'(bus_a.score), 1);
    tick = 1'b0; step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
